// File: rtl/memarb_pkg.sv
// Shared types and constants for the memory-port arbiter.
//   owner_t     : who owns a grant or an in-flight read (NONE, F, D, G)
//   arb_state_t : lock state of the arbiter (IDLE, LOCKED, COOLDOWN)
//   RD_LAT_MAX  : deepest supported RAM read latency
package memarb_pkg;

    localparam int RD_LAT_MAX = 4;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        F    = 2'd1,
        D    = 2'd2,
        G    = 2'd3
    } owner_t;

    typedef enum logic [1:0] {
        IDLE,
        LOCKED,
        COOLDOWN
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker between fetch (f) and load/store (d).
// On contention the requester that did not win last time is picked.
// The last-winner bit only moves when the caller actually issues the pick.
//   clk    : clock
//   rst_n  : synchronous reset, active-high; last winner becomes d
//   req_f  : fetch is eligible this cycle
//   req_d  : load/store is eligible this cycle
//   take   : the pick below is turned into a real grant this cycle
//   pick_f : fetch is picked
//   pick_d : load/store is picked
module rr_pick2
    import memarb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_f,
    input  logic req_d,
    input  logic take,
    output logic pick_f,
    output logic pick_d
);

    logic last_d;  // 1: d won the most recent f/d grant

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            last_d <= 1'b1;
        end else if (take) begin
            last_d <= pick_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        pick_f = 1'b0;
        pick_d = 1'b0;
        if (req_f && req_d) begin
            pick_f = last_d;
            pick_d = !last_d;
        end else begin
            pick_f = req_f;
            pick_d = req_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for three requesters: fetch (f), load/store (d),
// debug (g). One access is accepted per cycle; the grant is combinational.
// Debug has fixed top priority, f and d share round-robin. Load/store can lock
// the port for read-modify-write sequences, bounded by MAX_LOCK cycles and
// followed by one cycle in which d is refused. Read responses are routed back
// through an owner-tag shift pipeline matching the RAM read latency.
// Ports:
//   clk, rst_n              : clock; synchronous reset, active-high (1 = reset)
//   x_req/x_we/x_addr/x_wdata (x = f, d, g) : request side
//   x_gnt                   : request accepted this cycle
//   x_rvalid/x_rdata        : read response, RD_LAT cycles after the grant
//   d_lock                  : d keeps the port across consecutive accesses
//   ram_addr_a/ram_w_data_a/ram_wren_a/ram_r_data_a : RAM port A
//   busy                    : reads in flight or lock state not IDLE
module mem_arbiter
    import memarb_pkg::*;
#(
    parameter int RD_LAT   = 1,  // 1..RD_LAT_MAX
    parameter int MAX_LOCK = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        f_req,
    input  logic        f_we,
    input  logic [31:0] f_addr,
    input  logic [31:0] f_wdata,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    input  logic        d_lock,

    input  logic        g_req,
    input  logic        g_we,
    input  logic [31:0] g_addr,
    input  logic [31:0] g_wdata,
    output logic        g_gnt,
    output logic        g_rvalid,
    output logic [31:0] g_rdata,

    output logic [31:0] ram_addr_a,
    output logic [31:0] ram_w_data_a,
    output logic        ram_wren_a,
    input  logic [31:0] ram_r_data_a,

    output logic        busy
);

    localparam int LAT   = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : ((RD_LAT < 1) ? 1 : RD_LAT);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_t        state, state_d;
    logic [CNT_W-1:0]  lock_cnt, lock_cnt_d;   // cycles d has held the port, entry grant included
    owner_t            tag_pipe [LAT];
    owner_t            gnt_own;
    owner_t            new_tag;
    owner_t            rsp_own;

    logic lock_hold;
    logic eff_f, eff_d, eff_g;
    logic pick_f, pick_d, take;
    logic any_tag;

    // Eligibility: an active lock shuts out f and g; cooldown shuts out d.
    // Everything is suppressed while reset is asserted.
    always_comb begin
        lock_hold = (state == LOCKED) && d_lock;
        eff_g     = !rst_n && g_req && !lock_hold;
        eff_f     = !rst_n && f_req && !lock_hold;
        eff_d     = !rst_n && d_req && (state != COOLDOWN);
        take      = !eff_g && (eff_f || eff_d);
    end

    rr_pick2 u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_f  (eff_f),
        .req_d  (eff_d),
        .take   (take),
        .pick_f (pick_f),
        .pick_d (pick_d)
    );

    // Grant selection and RAM port mux.
    always_comb begin
        gnt_own      = NONE;
        ram_addr_a   = '0;
        ram_w_data_a = '0;
        ram_wren_a   = 1'b0;
        if (eff_g) begin
            gnt_own = G;
        end else if (pick_f) begin
            gnt_own = F;
        end else if (pick_d) begin
            gnt_own = D;
        end

        case (gnt_own)
            F: begin
                ram_addr_a   = f_addr;
                ram_w_data_a = f_wdata;
                ram_wren_a   = f_we;
            end
            D: begin
                ram_addr_a   = d_addr;
                ram_w_data_a = d_wdata;
                ram_wren_a   = d_we;
            end
            G: begin
                ram_addr_a   = g_addr;
                ram_w_data_a = g_wdata;
                ram_wren_a   = g_we;
            end
            default: ;
        endcase

        f_gnt   = (gnt_own == F);
        d_gnt   = (gnt_own == D);
        g_gnt   = (gnt_own == G);
        new_tag = (gnt_own != NONE && !ram_wren_a) ? gnt_own : NONE;
    end

    // Lock state machine. Dropping d_lock while LOCKED falls through to the
    // normal arbitration path in the same cycle. The forced release happens
    // once d has held the port MAX_LOCK cycles, counting the entry grant.
    always_comb begin
        state_d    = state;
        lock_cnt_d = lock_cnt;
        if (state == COOLDOWN) begin
            state_d    = IDLE;
            lock_cnt_d = '0;
        end else if (lock_hold) begin
            lock_cnt_d = lock_cnt + CNT_W'(1);
            if (lock_cnt >= CNT_W'(MAX_LOCK - 1)) begin
                state_d = COOLDOWN;
            end
        end else if (gnt_own == D && d_lock) begin
            lock_cnt_d = CNT_W'(1);
            state_d    = (MAX_LOCK <= 1) ? COOLDOWN : LOCKED;
        end else begin
            state_d    = IDLE;
            lock_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= IDLE;
            lock_cnt <= '0;
        end else begin
            state    <= state_d;
            lock_cnt <= lock_cnt_d;
        end
    end

    // NOTE: the tag pipeline is control state, not storage: it must be cleared
    // on reset so reads in flight at reset are dropped rather than delivered.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                tag_pipe[i] <= NONE;
            end
        end else begin
            tag_pipe[0] <= new_tag;
            for (int i = 1; i < LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Response routing; outputs are forced quiet during reset because the
    // pipeline itself only clears at the reset edge.
    always_comb begin
        any_tag = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            if (tag_pipe[i] != NONE) begin
                any_tag = 1'b1;
            end
        end
        rsp_own  = rst_n ? NONE : tag_pipe[LAT-1];
        f_rvalid = (rsp_own == F);
        d_rvalid = (rsp_own == D);
        g_rvalid = (rsp_own == G);
        f_rdata  = f_rvalid ? ram_r_data_a : '0;
        d_rdata  = d_rvalid ? ram_r_data_a : '0;
        g_rdata  = g_rvalid ? ram_r_data_a : '0;
        busy     = !rst_n && (any_tag || state != IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with RD_LAT=3, MAX_LOCK=8. A small RAM model
// returns {16'hDA7A, addr[15:0]} three cycles after an address is presented.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_mem_arbiter;

    localparam int RD_LAT = 3;
    localparam logic L = 1'b0;
    localparam logic H = 1'b1;
    // grant / rvalid vectors are {g, d, f}
    localparam logic [2:0] NO = 3'b000;
    localparam logic [2:0] GF = 3'b001;
    localparam logic [2:0] GD = 3'b010;
    localparam logic [2:0] GG = 3'b100;

    typedef struct {
        logic        rst;
        logic        f_req, f_we;
        logic [31:0] f_addr;
        logic        d_req, d_we;
        logic [31:0] d_addr;
        logic        d_lock;
        logic        g_req, g_we;
        logic [31:0] g_addr;
        logic [2:0]  e_gnt;
        logic [2:0]  e_rv;
        logic [31:0] e_raddr;
        logic        e_busy;
    } vec_t;

    logic        clk, rst_n;
    logic        f_req, f_we, f_gnt, f_rvalid;
    logic [31:0] f_addr, f_wdata, f_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_lock;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        g_req, g_we, g_gnt, g_rvalid;
    logic [31:0] g_addr, g_wdata, g_rdata;
    logic [31:0] ram_addr_a, ram_w_data_a, ram_r_data_a;
    logic        ram_wren_a, busy;

    logic [31:0] addr_pipe [RD_LAT];

    int errors = 0;
    int checks = 0;

    vec_t tbl1[$];
    vec_t tbl2[$];

    mem_arbiter #(.RD_LAT(RD_LAT), .MAX_LOCK(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .f_req        (f_req),
        .f_we         (f_we),
        .f_addr       (f_addr),
        .f_wdata      (f_wdata),
        .f_gnt        (f_gnt),
        .f_rvalid     (f_rvalid),
        .f_rdata      (f_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .d_lock       (d_lock),
        .g_req        (g_req),
        .g_we         (g_we),
        .g_addr       (g_addr),
        .g_wdata      (g_wdata),
        .g_gnt        (g_gnt),
        .g_rvalid     (g_rvalid),
        .g_rdata      (g_rdata),
        .ram_addr_a   (ram_addr_a),
        .ram_w_data_a (ram_w_data_a),
        .ram_wren_a   (ram_wren_a),
        .ram_r_data_a (ram_r_data_a),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: fixed read latency, data derived from the address.
    always_ff @(posedge clk) begin
        addr_pipe[0] <= ram_addr_a;
        for (int i = 1; i < RD_LAT; i++) begin
            addr_pipe[i] <= addr_pipe[i-1];
        end
    end
    assign ram_r_data_a = {16'hDA7A, addr_pipe[RD_LAT-1][15:0]};

    function automatic logic [31:0] wd(input logic [31:0] a);
        return {16'hBEEF, a[15:0]};
    endfunction

    function automatic logic [31:0] rd(input logic [31:0] a);
        return {16'hDA7A, a[15:0]};
    endfunction

    function automatic vec_t mk(input logic rst,
                                input logic fr, input logic fw, input logic [31:0] fa,
                                input logic dr, input logic dw, input logic [31:0] da,
                                input logic dl,
                                input logic gr, input logic gw, input logic [31:0] ga,
                                input logic [2:0] eg, input logic [2:0] er,
                                input logic [31:0] ea, input logic eb);
        vec_t v;
        v.rst = rst;
        v.f_req = fr; v.f_we = fw; v.f_addr = fa;
        v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_lock = dl;
        v.g_req = gr; v.g_we = gw; v.g_addr = ga;
        v.e_gnt = eg; v.e_rv = er; v.e_raddr = ea; v.e_busy = eb;
        return v;
    endfunction

    // No requests, out of reset.
    function automatic vec_t idle(input logic [2:0] er, input logic [31:0] ea, input logic eb);
        return mk(L, L, L, 32'h0, L, L, 32'h0, L, L, L, 32'h0, NO, er, ea, eb);
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n   = v.rst;
        f_req   = v.f_req;  f_we = v.f_we;  f_addr = v.f_addr;  f_wdata = wd(v.f_addr);
        d_req   = v.d_req;  d_we = v.d_we;  d_addr = v.d_addr;  d_wdata = wd(v.d_addr);
        d_lock  = v.d_lock;
        g_req   = v.g_req;  g_we = v.g_we;  g_addr = v.g_addr;  g_wdata = wd(v.g_addr);
    endtask

    task automatic apply(input vec_t v, input int cyc);
        logic [31:0] ea, ewd;
        logic        ewe;
        logic [95:0] erd;
        drive(v);
        #1;
        ea = 32'h0; ewd = 32'h0; ewe = 1'b0;
        case (v.e_gnt)
            GF: begin ea = v.f_addr; ewd = wd(v.f_addr); ewe = v.f_we; end
            GD: begin ea = v.d_addr; ewd = wd(v.d_addr); ewe = v.d_we; end
            GG: begin ea = v.g_addr; ewd = wd(v.g_addr); ewe = v.g_we; end
            default: ;
        endcase
        erd = {v.e_rv[2] ? rd(v.e_raddr) : 32'h0,
               v.e_rv[1] ? rd(v.e_raddr) : 32'h0,
               v.e_rv[0] ? rd(v.e_raddr) : 32'h0};
        check($sformatf("c%0d gnt{g,d,f}", cyc), 96'({g_gnt, d_gnt, f_gnt}), 96'(v.e_gnt));
        check($sformatf("c%0d rvalid{g,d,f}", cyc), 96'({g_rvalid, d_rvalid, f_rvalid}), 96'(v.e_rv));
        check($sformatf("c%0d rdata{g,d,f}", cyc), {g_rdata, d_rdata, f_rdata}, erd);
        check($sformatf("c%0d busy", cyc), 96'(busy), 96'(v.e_busy));
        check($sformatf("c%0d ram_addr_a", cyc), 96'(ram_addr_a), 96'(ea));
        check($sformatf("c%0d ram_w_data_a", cyc), 96'(ram_w_data_a), 96'(ewd));
        check($sformatf("c%0d ram_wren_a", cyc), 96'(ram_wren_a), 96'(ewe));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [11:0] d_pat, f_pat, g_pat;
        logic        rv_seen;
        vec_t        v;

        // ---- part 1: reset, priority, round-robin, lock released by d_lock ----
        // c0-c1: reset with every requester active
        tbl1.push_back(mk(H, H, L, 32'h100, H, L, 32'h200, L, H, L, 32'h300, NO, NO, 32'h0, L));
        tbl1.push_back(mk(H, H, L, 32'h100, H, L, 32'h200, L, H, L, 32'h300, NO, NO, 32'h0, L));
        // c2: all three request -> g
        tbl1.push_back(mk(L, H, L, 32'h100, H, L, 32'h200, L, H, L, 32'h300, GG, NO, 32'h0, L));
        // c3-c6: f/d contention alternates f,d,f,d (f first: last winner = d)
        tbl1.push_back(mk(L, H, L, 32'h100, H, L, 32'h200, L, L, L, 32'h0, GF, NO, 32'h0, H));
        tbl1.push_back(mk(L, H, L, 32'h100, H, L, 32'h200, L, L, L, 32'h0, GD, NO, 32'h0, H));
        tbl1.push_back(mk(L, H, L, 32'h100, H, L, 32'h200, L, L, L, 32'h0, GF, GG, 32'h300, H));
        tbl1.push_back(mk(L, H, L, 32'h100, H, L, 32'h200, L, L, L, 32'h0, GD, GF, 32'h100, H));
        // c7-c10: drain responses
        tbl1.push_back(idle(GD, 32'h200, H));
        tbl1.push_back(idle(GF, 32'h100, H));
        tbl1.push_back(idle(GD, 32'h200, H));
        tbl1.push_back(idle(NO, 32'h0, L));
        // c11: d locked read
        tbl1.push_back(mk(L, L, L, 32'h0, H, L, 32'h400, H, L, L, 32'h0, GD, NO, 32'h0, L));
        // c12: d locked write, g stalled
        tbl1.push_back(mk(L, L, L, 32'h0, H, H, 32'h404, H, H, L, 32'h500, GD, NO, 32'h0, H));
        // c13: lock held with d idle, g still stalled
        tbl1.push_back(mk(L, L, L, 32'h0, L, L, 32'h0, H, H, L, 32'h500, NO, NO, 32'h0, H));
        // c14: d_lock drops -> g granted same cycle; d read data returns
        tbl1.push_back(mk(L, L, L, 32'h0, L, L, 32'h0, L, H, L, 32'h500, GG, GD, 32'h400, H));
        tbl1.push_back(idle(NO, 32'h0, H));
        tbl1.push_back(idle(NO, 32'h0, H));
        tbl1.push_back(idle(GG, 32'h500, H));
        tbl1.push_back(idle(NO, 32'h0, L));

        // ---- part 2: after forced lock release ----
        // c31: d_lock dropped, state leaves LOCKED this cycle
        tbl2.push_back(idle(NO, 32'h0, H));
        tbl2.push_back(idle(NO, 32'h0, L));
        // c33-c37: back-to-back R,W,R,W,R from mixed owners
        tbl2.push_back(mk(L, H, L, 32'h800, L, L, 32'h0, L, L, L, 32'h0, GF, NO, 32'h0, L));
        tbl2.push_back(mk(L, L, L, 32'h0, H, H, 32'h900, L, L, L, 32'h0, GD, NO, 32'h0, H));
        tbl2.push_back(mk(L, L, L, 32'h0, L, L, 32'h0, L, H, L, 32'hA00, GG, NO, 32'h0, H));
        tbl2.push_back(mk(L, H, H, 32'hB00, L, L, 32'h0, L, L, L, 32'h0, GF, GF, 32'h800, H));
        tbl2.push_back(mk(L, L, L, 32'h0, H, L, 32'hC00, L, L, L, 32'h0, GD, NO, 32'h0, H));
        tbl2.push_back(idle(GG, 32'hA00, H));
        tbl2.push_back(idle(NO, 32'h0, H));
        tbl2.push_back(idle(GD, 32'hC00, H));
        // c41-c43: three reads, then reset drops them all
        tbl2.push_back(mk(L, H, L, 32'hE00, L, L, 32'h0, L, L, L, 32'h0, GF, NO, 32'h0, L));
        tbl2.push_back(mk(L, L, L, 32'h0, H, L, 32'hE04, L, L, L, 32'h0, GD, NO, 32'h0, H));
        tbl2.push_back(mk(L, H, L, 32'hE08, L, L, 32'h0, L, L, L, 32'h0, GF, NO, 32'h0, H));
        // c44: one reset cycle with requests present
        tbl2.push_back(mk(H, H, L, 32'hE0C, H, L, 32'hE10, L, H, L, 32'hE14, NO, NO, 32'h0, L));
        tbl2.push_back(idle(NO, 32'h0, L));
        tbl2.push_back(idle(NO, 32'h0, L));
        // c47: contention right after reset -> f (last winner reset to d)
        tbl2.push_back(mk(L, H, L, 32'hF00, H, L, 32'hF04, L, L, L, 32'h0, GF, NO, 32'h0, L));
        tbl2.push_back(idle(NO, 32'h0, H));
        tbl2.push_back(idle(NO, 32'h0, H));
        tbl2.push_back(idle(GF, 32'hF00, H));
        tbl2.push_back(idle(NO, 32'h0, L));

        drive(mk(H, L, L, 32'h0, L, L, 32'h0, L, L, L, 32'h0, NO, NO, 32'h0, L));
        @(negedge clk);

        foreach (tbl1[i]) apply(tbl1[i], i);

        // ---- c19-c30: d_lock held 12 cycles, d writing throughout ----
        // f asks (write) only at cycle 8, which is the cooldown slot.
        d_pat = '0; f_pat = '0; g_pat = '0; rv_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            v = mk(L, (i == 8), H, 32'h700, H, H, 32'h600, H, L, L, 32'h0, NO, NO, 32'h0, L);
            drive(v);
            #1;
            d_pat[i] = d_gnt;
            f_pat[i] = f_gnt;
            g_pat[i] = g_gnt;
            rv_seen  = rv_seen | f_rvalid | d_rvalid | g_rvalid;
            @(posedge clk);
            @(negedge clk);
        end
        check("lock d grant pattern", 96'(d_pat), 96'(12'hEFF));
        check("lock f grant pattern", 96'(f_pat), 96'(12'h100));
        check("lock g grant pattern", 96'(g_pat), 96'(12'h000));
        check("lock no rvalid", 96'(rv_seen), 96'(1'b0));

        foreach (tbl2[i]) apply(tbl2[i], i + 31);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
